// File: rtl/spatz_l1d_maint_ctrl_pkg.sv
// Shared types for the L1D maintenance controller.
//   maint_insn_e  : 2-bit maintenance instruction from the cluster peripheral
//   maint_op_e    : 2-bit per-line operation sent to the tag/data controller
//   maint_state_e : controller FSM state
//   insn_to_op()  : maps an instruction to its per-line operation
package spatz_l1d_maint_pkg;

  typedef enum logic [1:0] {
    INSN_FLUSH       = 2'b00,
    INSN_INVAL       = 2'b01,
    INSN_FLUSH_INVAL = 2'b10,
    INSN_RSVD        = 2'b11
  } maint_insn_e;

  typedef enum logic [1:0] {
    OP_FLUSH       = 2'b00,
    OP_INVAL       = 2'b01,
    OP_FLUSH_INVAL = 2'b10
  } maint_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WALK,
    ST_DRAIN,
    ST_DONE
  } maint_state_e;

  // The reserved encoding never issues line ops, so its mapping is irrelevant.
  function automatic maint_op_e insn_to_op(maint_insn_e insn);
    case (insn)
      INSN_INVAL:       return OP_INVAL;
      INSN_FLUSH_INVAL: return OP_FLUSH_INVAL;
      default:          return OP_FLUSH;
    endcase
  endfunction

endpackage

// File: rtl/spatz_l1d_maint_ctrl_if.sv
// Bus bundle between the maintenance controller and its environment
// (cluster peripheral on the insn side, L1D tag/data controller on the line-op side).
//   insn / insn_valid / insn_ready / spm_size / busy : peripheral side
//   maint_req_* / maint_rsp_valid                    : line-op side
// Modports: slave = the maintenance controller, master = its environment.
interface spatz_l1d_maint_ctrl_if
  import spatz_l1d_maint_pkg::*;
#(
  parameter int unsigned SetIdxWidth = 6,
  parameter int unsigned WayIdxWidth = 2
);
  logic [1:0]             insn;
  logic                   insn_valid;
  logic                   insn_ready;
  logic [5:0]             spm_size;
  logic                   busy;
  logic                   maint_req_valid;
  logic                   maint_req_ready;
  logic [SetIdxWidth-1:0] maint_req_set;
  logic [WayIdxWidth-1:0] maint_req_way;
  maint_op_e              maint_req_op;
  logic                   maint_rsp_valid;

  modport master (
    output insn, insn_valid, spm_size, maint_req_ready, maint_rsp_valid,
    input  insn_ready, busy, maint_req_valid, maint_req_set, maint_req_way, maint_req_op
  );

  modport slave (
    input  insn, insn_valid, spm_size, maint_req_ready, maint_rsp_valid,
    output insn_ready, busy, maint_req_valid, maint_req_set, maint_req_way, maint_req_op
  );
endinterface

// File: rtl/spatz_l1d_maint_ctrl_walk.sv
// Set/way address generator for the maintenance walk.
// Order is set-major, way-minor; each set covers ways start_way..NrWays-1.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : restart the walk at (0, start_way_i) and remember start_way_i
//   start_way_i   : first non-SPM way
//   advance_i     : step to the next line
//   set_o, way_o  : current line
//   last_o        : current line is the final one of the walk
module spatz_l1d_maint_walk #(
  parameter int unsigned NrSets = 64,
  parameter int unsigned NrWays = 4,
  localparam int unsigned SetIdxWidth = $clog2(NrSets),
  localparam int unsigned WayIdxWidth = $clog2(NrWays)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_i,
  input  logic [WayIdxWidth-1:0] start_way_i,
  input  logic                   advance_i,
  output logic [SetIdxWidth-1:0] set_o,
  output logic [WayIdxWidth-1:0] way_o,
  output logic                   last_o
);
  localparam logic [SetIdxWidth-1:0] SetLast = SetIdxWidth'(NrSets - 1);
  localparam logic [WayIdxWidth-1:0] WayLast = WayIdxWidth'(NrWays - 1);

  logic [SetIdxWidth-1:0] set_q, set_d;
  logic [WayIdxWidth-1:0] way_q, way_d, start_q, start_d;

  always_comb begin
    set_d   = set_q;
    way_d   = way_q;
    start_d = start_q;
    if (load_i) begin
      set_d   = '0;
      way_d   = start_way_i;
      start_d = start_way_i;
    end else if (advance_i) begin
      // Wrapping back to the latched start way keeps SPM ways untouched in every set.
      if (way_q == WayLast) begin
        way_d = start_q;
        set_d = set_q + SetIdxWidth'(1);
      end else begin
        way_d = way_q + WayIdxWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      set_q   <= '0;
      way_q   <= '0;
      start_q <= '0;
    end else begin
      set_q   <= set_d;
      way_q   <= way_d;
      start_q <= start_d;
    end
  end

  assign set_o  = set_q;
  assign way_o  = way_q;
  assign last_o = (set_q == SetLast) && (way_q == WayLast);
endmodule

// File: rtl/spatz_l1d_maint_ctrl.sv
// L1D maintenance responder: accepts flush/invalidate insns from the cluster
// peripheral, walks every non-SPM line issuing per-line ops, waits for all
// responses and then returns a one-cycle insn_ready pulse.
//   clk_i, rst_ni : clock, async active-low reset
//   bus_if        : spatz_l1d_maint_ctrl_if.slave (insn + line-op handshakes)
//   perf_lines_o  : accepted line ops of the last insn  (SPATZ_L1D_MAINT_PERF_EN only)
//   perf_cycles_o : busy cycles of the last insn         (SPATZ_L1D_MAINT_PERF_EN only)
// Optional feature macro: SPATZ_L1D_MAINT_PERF_EN.
module spatz_l1d_maint_ctrl
  import spatz_l1d_maint_pkg::*;
#(
  parameter int unsigned NrSets         = 64,
  parameter int unsigned NrWays         = 4,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned SetIdxWidth   = $clog2(NrSets),
  localparam int unsigned WayIdxWidth   = $clog2(NrWays)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  spatz_l1d_maint_ctrl_if.slave bus_if
`ifdef SPATZ_L1D_MAINT_PERF_EN
  ,
  output logic [31:0]          perf_lines_o,
  output logic [31:0]          perf_cycles_o
`endif
);
  localparam int unsigned OutWidth = $clog2(MaxOutstanding + 1);
  localparam logic [OutWidth-1:0] OutMax = OutWidth'(MaxOutstanding);

  maint_state_e           state_q, state_d;
  maint_insn_e            insn_q, insn_d;
  logic [OutWidth-1:0]    outstanding_q, outstanding_d;
  logic                   req_valid, req_hs, rsp_ok, accept, spm_full;
  logic                   walk_last;
  logic [SetIdxWidth-1:0] walk_set;
  logic [WayIdxWidth-1:0] walk_way;

  // SPM sizes at or above NrWays leave no cache ways to walk.
  assign spm_full  = {1'b0, bus_if.spm_size} >= 7'(NrWays);
  assign req_valid = (state_q == ST_WALK) && (outstanding_q != OutMax);
  assign req_hs    = req_valid && bus_if.maint_req_ready;
  assign rsp_ok    = bus_if.maint_rsp_valid && (outstanding_q != '0);

  // Outstanding counter: a handshake and a response in the same cycle cancel.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({req_hs, rsp_ok})
      2'b10:   outstanding_d = outstanding_q + OutWidth'(1);
      2'b01:   outstanding_d = outstanding_q - OutWidth'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // FSM next state. Drain completion looks at outstanding_d so a response
  // arriving in the same cycle already counts.
  always_comb begin
    state_d = state_q;
    insn_d  = insn_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.insn_valid) begin
          accept  = 1'b1;
          insn_d  = maint_insn_e'(bus_if.insn);
          state_d = (maint_insn_e'(bus_if.insn) == INSN_RSVD || spm_full) ? ST_DONE : ST_WALK;
        end
      end
      ST_WALK: begin
        if (req_hs && walk_last) state_d = (outstanding_d == '0) ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outstanding_d == '0) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      insn_q        <= INSN_FLUSH;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      insn_q        <= insn_d;
      outstanding_q <= outstanding_d;
    end
  end

  spatz_l1d_maint_walk #(
    .NrSets (NrSets),
    .NrWays (NrWays)
  ) i_walk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (accept),
    .start_way_i (bus_if.spm_size[WayIdxWidth-1:0]),
    .advance_i   (req_hs),
    .set_o       (walk_set),
    .way_o       (walk_way),
    .last_o      (walk_last)
  );

  assign bus_if.maint_req_valid = req_valid;
  assign bus_if.maint_req_set   = walk_set;
  assign bus_if.maint_req_way   = walk_way;
  assign bus_if.maint_req_op    = insn_to_op(insn_q);
  assign bus_if.insn_ready      = (state_q == ST_DONE);
  assign bus_if.busy            = (state_q != ST_IDLE);

`ifdef SPATZ_L1D_MAINT_PERF_EN
  logic [31:0] perf_lines_q, perf_cycles_q;

  // Counters restart on acceptance and saturate instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_lines_q  <= '0;
      perf_cycles_q <= '0;
    end else if (accept) begin
      perf_lines_q  <= '0;
      perf_cycles_q <= '0;
    end else begin
      if (req_hs && perf_lines_q != '1) perf_lines_q <= perf_lines_q + 32'd1;
      if (state_q != ST_IDLE && perf_cycles_q != '1) perf_cycles_q <= perf_cycles_q + 32'd1;
    end
  end

  assign perf_lines_o  = perf_lines_q;
  assign perf_cycles_o = perf_cycles_q;
`endif

  // The peripheral lock must keep new insns away while busy.
  a_insn_while_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus_if.insn_valid && state_q != ST_IDLE));

  // Every response must belong to an accepted request.
  a_rsp_without_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus_if.maint_rsp_valid && outstanding_q == '0));
endmodule
